// File: rtl/sha256_block_ctrl_if.sv
// sha256_block_ctrl_if
//   Block-in / digest-out handshake bundle for the SHA-256 block engine.
//   in_valid/in_ready/in_first/in_block : pre-padded 512-bit block channel
//   out_valid/out_ready/out_digest      : 256-bit digest channel
//   master = front-end / consumer side, slave = engine side.
interface sha256_block_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic         in_first;
  logic [511:0] in_block;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_digest;

  modport master (
    output in_valid, in_first, in_block, out_ready,
    input  in_ready, out_valid, out_digest
  );

  modport slave (
    input  in_valid, in_first, in_block, out_ready,
    output in_ready, out_valid, out_digest
  );
endinterface

// File: rtl/sha256_block_ctrl.sv
// sha256_block_ctrl
//   Iterative SHA-256 compression engine. One pre-padded 512-bit block per
//   in_valid&in_ready; ROUNDS_PER_CYCLE rounds per clock over a shared round
//   datapath, message schedule expanded on the fly in a 16-word window.
//   Ports:
//     clock    : rising-edge clock
//     reset_n  : synchronous active-low reset
//     bus      : slave side of sha256_block_ctrl_if (block in, digest out)
//     busy     : engine not in IDLE
module sha256_block_ctrl #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  sha256_block_ctrl_if.slave  bus,
  output logic                busy
);

  localparam int R          = ROUNDS_PER_CYCLE;
  localparam int NUM_CYCLES = 64 / ROUNDS_PER_CYCLE;

  if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4) begin : g_bad_rpc
    $error("sha256_block_ctrl: ROUNDS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [31:0] IV_W [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} state_t;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t        r_state, w_next;
  logic [5:0]    r_cnt;
  logic [31:0]   r_h  [8];   // chaining value H0..H7
  logic [31:0]   r_wk [8];   // working regs a..h
  logic [31:0]   r_w  [16];  // schedule window, r_w[0] = W[t]
  logic [255:0]  r_digest;

  logic [31:0]   w_ext  [16+R];   // window plus the R words generated this cycle
  logic [31:0]   w_v    [R+1][8]; // working regs after each chained round
  logic [31:0]   w_t1   [R];
  logic [31:0]   w_t2   [R];
  logic [5:0]    w_kidx [R];
  logic [31:0]   w_hsum [8];
  logic [255:0]  w_hflat;
  logic          w_last;

  assign w_last = (r_cnt == 6'(NUM_CYCLES - 1));

  // Round datapath: R rounds chained combinationally. Words generated late
  // in the cycle may feed later new words (t-2 taps), so the window is built
  // up sequentially in w_ext.
  always_comb begin
    w_ext   = '{default: '0};
    w_v     = '{default: '{default: '0}};
    w_t1    = '{default: '0};
    w_t2    = '{default: '0};
    w_kidx  = '{default: '0};
    w_hsum  = '{default: '0};
    w_hflat = '0;
    for (int i = 0; i < 16; i++) w_ext[i] = r_w[i];
    for (int k = 0; k < R; k++)
      w_ext[16+k] = ssig1(w_ext[14+k]) + w_ext[9+k] + ssig0(w_ext[1+k]) + w_ext[k];
    w_v[0] = r_wk;
    for (int k = 0; k < R; k++) begin
      w_kidx[k] = 6'(int'(r_cnt) * R + k);
      w_t1[k] = w_v[k][7] + bsig1(w_v[k][4])
              + ((w_v[k][4] & w_v[k][5]) ^ (~w_v[k][4] & w_v[k][6]))
              + K_ROM[w_kidx[k]] + w_ext[k];
      w_t2[k] = bsig0(w_v[k][0])
              + ((w_v[k][0] & w_v[k][1]) ^ (w_v[k][0] & w_v[k][2]) ^ (w_v[k][1] & w_v[k][2]));
      w_v[k+1][0] = w_t1[k] + w_t2[k];
      w_v[k+1][1] = w_v[k][0];
      w_v[k+1][2] = w_v[k][1];
      w_v[k+1][3] = w_v[k][2];
      w_v[k+1][4] = w_v[k][3] + w_t1[k];
      w_v[k+1][5] = w_v[k][4];
      w_v[k+1][6] = w_v[k][5];
      w_v[k+1][7] = w_v[k][6];
    end
    for (int i = 0; i < 8; i++) begin
      w_hsum[i] = r_h[i] + r_wk[i];
      w_hflat[255-32*i -: 32] = w_hsum[i];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Outputs decode only the registered state: no in_* -> out_* path.
  always_comb begin
    w_next        = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b1;
    case (r_state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        busy         = 1'b0;
        if (bus.in_valid) w_next = S_ROUND;
      end
      S_ROUND: if (w_last) w_next = S_FINAL;
      S_FINAL: w_next = S_DONE;
      S_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_h      <= IV_W;
      r_wk     <= '{default: '0};
      r_w      <= '{default: '0};
      r_digest <= {IV_W[0], IV_W[1], IV_W[2], IV_W[3], IV_W[4], IV_W[5], IV_W[6], IV_W[7]};
    end else begin
      case (r_state)
        S_IDLE: if (bus.in_valid) begin
          for (int i = 0; i < 16; i++) r_w[i] <= bus.in_block[511-32*i -: 32];
          if (bus.in_first) begin
            r_h  <= IV_W;
            r_wk <= IV_W;
          end else begin
            r_wk <= r_h;
          end
          r_cnt <= '0;
        end
        S_ROUND: begin
          r_wk <= w_v[R];
          for (int i = 0; i < 16; i++) r_w[i] <= w_ext[i+R];
          r_cnt <= r_cnt + 6'd1;
        end
        S_FINAL: begin
          r_h      <= w_hsum;
          r_digest <= w_hflat;
        end
        default: ;
      endcase
    end
  end

  assign bus.out_digest = r_digest;

endmodule

// File: tb/tb_sha256_block_ctrl.sv
// tb_sha256_block_ctrl
//   Drives three engines (R = 1, 2, 4) with identical stimulus and checks each
//   cycle against a transaction-level SHA-256 model: expected handshake
//   timing from accept time, expected digest from a plain software
//   compression function.
module tb_sha256_block_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset_n  = 1'b0;
  logic         tb_valid = 1'b0;
  logic         tb_first = 1'b0;
  logic         tb_oready = 1'b1;
  logic [511:0] tb_block = '0;

  sha256_block_ctrl_if bus1 ();
  sha256_block_ctrl_if bus2 ();
  sha256_block_ctrl_if bus4 ();
  logic busy1, busy2, busy4;

  assign bus1.in_valid = tb_valid;  assign bus1.in_first = tb_first;
  assign bus1.in_block = tb_block;  assign bus1.out_ready = tb_oready;
  assign bus2.in_valid = tb_valid;  assign bus2.in_first = tb_first;
  assign bus2.in_block = tb_block;  assign bus2.out_ready = tb_oready;
  assign bus4.in_valid = tb_valid;  assign bus4.in_first = tb_first;
  assign bus4.in_block = tb_block;  assign bus4.out_ready = tb_oready;

  sha256_block_ctrl #(.ROUNDS_PER_CYCLE(1)) u_r1 (.clock(clock), .reset_n(reset_n), .bus(bus1.slave), .busy(busy1));
  sha256_block_ctrl #(.ROUNDS_PER_CYCLE(2)) u_r2 (.clock(clock), .reset_n(reset_n), .bus(bus2.slave), .busy(busy2));
  sha256_block_ctrl #(.ROUNDS_PER_CYCLE(4)) u_r4 (.clock(clock), .reset_n(reset_n), .bus(bus4.slave), .busy(busy4));

  logic         rdy [3];
  logic         vld [3];
  logic         bsy [3];
  logic [255:0] dig [3];
  assign rdy[0] = bus1.in_ready; assign vld[0] = bus1.out_valid; assign bsy[0] = busy1; assign dig[0] = bus1.out_digest;
  assign rdy[1] = bus2.in_ready; assign vld[1] = bus2.out_valid; assign bsy[1] = busy2; assign dig[1] = bus2.out_digest;
  assign rdy[2] = bus4.in_ready; assign vld[2] = bus4.out_valid; assign bsy[2] = busy4; assign dig[2] = bus4.out_digest;

  localparam int NCY [3] = '{64, 32, 16};
  localparam int RPC [3] = '{1, 2, 4};

  localparam logic [255:0] IV  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [511:0] B_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] B_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] B_TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] B_TWO2  = {480'h0, 32'h000001c0};

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook SHA-256 compression: full 64-word schedule up front, then rounds.
  function automatic logic [255:0] compress(input logic [255:0] h, input logic [511:0] blk);
    logic [31:0]  w [64];
    logic [31:0]  v [8];
    logic [31:0]  t1, t2, s0, s1;
    logic [255:0] res;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    for (int i = 0; i < 8; i++) v[i] = h[255-32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[255-32*i -: 32] = h[255-32*i -: 32] + v[i];
    return res;
  endfunction

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Model state, per engine: pend = block in flight, age = edges since accept.
  bit           started = 1'b0;
  bit           pend [3] = '{default: 1'b0};
  int           age  [3] = '{default: 0};
  logic [255:0] hm   [3] = '{default: IV};
  logic [255:0] expd [3] = '{default: '0};
  logic [255:0] last [3] = '{default: '0};

  // Compare current outputs, then advance the model over the coming edge
  // using the inputs that edge will sample (inputs move at posedge+1).
  initial begin
    forever begin
      @(negedge clock);
      if (started) begin
        for (int d = 0; d < 3; d++) begin
          automatic bit ev = pend[d] && (age[d] >= NCY[d] + 1);
          chk($sformatf("in_ready R%0d", RPC[d]), 256'(rdy[d]), 256'(!pend[d]));
          chk($sformatf("busy R%0d", RPC[d]),     256'(bsy[d]), 256'(pend[d]));
          chk($sformatf("out_valid R%0d", RPC[d]), 256'(vld[d]), 256'(ev));
          if (ev) chk($sformatf("digest R%0d", RPC[d]), dig[d], expd[d]);
        end
      end
      if (!reset_n) begin
        started = 1'b1;
        for (int d = 0; d < 3; d++) begin pend[d] = 1'b0; hm[d] = IV; end
      end else begin
        for (int d = 0; d < 3; d++) begin
          if (!pend[d]) begin
            if (tb_valid) begin
              hm[d]   = compress(tb_first ? IV : hm[d], tb_block);
              expd[d] = hm[d];
              pend[d] = 1'b1;
              age[d]  = 0;
            end
          end else if (age[d] >= NCY[d] + 1 && tb_oready) begin
            last[d] = dig[d];
            pend[d] = 1'b0;
          end else begin
            age[d]++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic bit all_idle();
    return !pend[0] && !pend[1] && !pend[2];
  endfunction

  task automatic wait_idle(input string name);
    int n = 0;
    while (!all_idle() && n < 400) begin tick(); n++; end
    if (!all_idle()) begin
      nvec++; nerr++;
      $display("FAIL %s: timeout waiting for idle", name);
    end
  endtask

  task automatic send(input logic [511:0] blk, input logic first);
    wait_idle("send");
    tb_block = blk;
    tb_first = first;
    tb_valid = 1'b1;
    tick();
    tb_valid = 1'b0;
  endtask

  function automatic logic [511:0] rnd_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  task automatic chk_last(input string name, input logic [255:0] exp);
    for (int d = 0; d < 3; d++) chk($sformatf("%s R%0d", name, RPC[d]), last[d], exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Pin the reference model itself to known vectors.
    chk("model abc", compress(IV, B_ABC), D_ABC);
    chk("model empty", compress(IV, B_EMPTY), D_EMPTY);
    chk("model two-block", compress(compress(IV, B_TWO1), B_TWO2), D_TWO);

    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    for (int d = 0; d < 3; d++) chk($sformatf("reset digest R%0d", RPC[d]), dig[d], IV);

    send(B_ABC, 1'b1);    wait_idle("abc");   chk_last("abc", D_ABC);
    send(B_EMPTY, 1'b1);  wait_idle("empty"); chk_last("empty", D_EMPTY);
    send(B_TWO1, 1'b1);
    send(B_TWO2, 1'b0);   wait_idle("two");   chk_last("two-block", D_TWO);
    send(B_ABC, 1'b1);    wait_idle("abc2");  chk_last("abc after chain", D_ABC);

    // Back-pressure: hold DONE, poke in_valid with other blocks meanwhile.
    tb_oready = 1'b0;
    send(B_EMPTY, 1'b1);
    begin
      int n = 0;
      while (!(vld[0] && vld[1] && vld[2]) && n < 200) begin tick(); n++; end
      if (n >= 200) begin nvec++; nerr++; $display("FAIL backpressure: out_valid never rose"); end
    end
    for (int i = 0; i < 20; i++) begin
      tb_block = rnd_block();
      tb_first = 1'(($urandom % 2));
      tb_valid = 1'(($urandom % 2));
      tick();
    end
    tb_valid  = 1'b0;
    tb_oready = 1'b1;
    wait_idle("backpressure");
    chk_last("backpressure", D_EMPTY);

    // Reset in the middle of a block, then chain=0 must start from the IV.
    send(rnd_block(), 1'b1);
    repeat (29) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    send(B_ABC, 1'b0);    wait_idle("reset abc"); chk_last("abc after reset", D_ABC);

    // Random traffic with random back-pressure and chaining.
    for (int i = 0; i < 1500; i++) begin
      tb_oready = 1'(($urandom % 4) != 0);
      tb_valid  = 1'(($urandom % 3) == 0);
      tb_first  = 1'(($urandom % 2));
      tb_block  = rnd_block();
      tick();
    end
    tb_valid  = 1'b0;
    tb_oready = 1'b1;
    wait_idle("random");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
